div_restoring_ctrl: RTL and testbench
=====================================

Name: div_restoring_ctrl

Overview:
- Control and datapath-arithmetic stage for the N-bit restoring unsigned divider.
- Sits directly upstream of the A/Q shift register. It drives that register's load/shift/hab_A/set_Q0 strobes and its (N+1)-bit operando input, and reads back its regA output.
- Latches the divisor on start, sequences N shift/subtract/restore iterations, and reports completion with a one-cycle done pulse.
- After done, quotient is in regQ and remainder in regA[N-1:0] of the downstream register.

Parameters:
- N, 4, dividend/divisor/quotient width in bits; counter width = clog2(N+1).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a division; sampled only in IDLE
- divisor  input  N  divisor M, captured on the accepted start
- regA  input  N+1  current A register value, fed back from the A/Q register
- load  output  1  strobe: A<=0, Q<=dividend
- shift  output  1  strobe: {A,Q} shift left by 1
- hab_A  output  1  strobe: A<=operando
- set_Q0  output  1  strobe: Q[0]<=1
- operando  output  N+1  regA minus latched divisor, truncated to N+1 bits
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in state DONE
- div_by_zero  output  1  sticky error flag; cleared on the next accepted start

Behaviour:
- Reset: state=IDLE, M_reg=0, cnt=0. All outputs are 0, except operando, which equals regA minus 0.
- Mutual exclusion: at most one of load/shift/hab_A/set_Q0 is high in any cycle. The downstream register prioritises load>shift>hab_A>set_Q0 and performs one action per edge.
- Arithmetic:
  - diff = {1'b0,regA} - {2'b0,M_reg}, computed at N+2 bits and combinational.
  - operando = diff[N:0].
  - Non-negative when diff[N+1]==0. The extra bit is needed because post-shift A can reach 2M-1 and exceed 2^N.
- State IDLE:
  - On start=1: M_reg<=divisor and div_by_zero<=0.
  - If divisor==0: set div_by_zero<=1 and go to DONE. No load is issued and the downstream register is untouched.
  - Otherwise go to LOAD.
  - start=0: stay in IDLE.
- State LOAD: load=1; cnt<=N; next state SHIFT.
- State SHIFT: shift=1; next state CHECK.
- State CHECK:
  - cnt<=cnt-1.
  - If diff non-negative: hab_A=1 (Mealy output on regA), next state SETQ.
  - Otherwise: no strobe. Next state is SHIFT if cnt>1, else DONE.
- State SETQ: set_Q0=1. Next state is SHIFT if cnt!=0, else DONE.
- State DONE: done=1, busy=1; next state IDLE unconditionally.
- start while busy: ignored and not queued. M_reg and divisor changes have no effect mid-operation.
- Reset mid-operation: immediate return to IDLE with outputs 0. Downstream contents are don't-care until the next load.
- Latency, counted from the edge that samples start to the edge entering DONE:
  - 1 + 2N + k cycles, where k = number of quotient 1-bits.
  - done is visible in the following cycle.
  - Divide-by-zero: DONE entered on the first edge.
- Back-to-back: start can be accepted in the IDLE cycle right after DONE. Minimum spacing is DONE followed by IDLE.

Test Plan (bench instantiates this block plus the A/Q register, N=4):
- dividend=13, divisor=3 -> Q=4, R=1. done enters 1+8+1=10 edges after start. div_by_zero=0.
- dividend=15, divisor=1 -> Q=15, R=0. hab_A/set_Q0 fire in all 4 iterations. Latency 13 edges.
- dividend=7, divisor=7 -> Q=1, R=0. Then dividend=2, divisor=9 -> Q=0, R=2 with no hab_A pulses. Latency 9 edges.
- divisor=0 -> DONE one edge after start. div_by_zero=1, no load/shift pulses. The next valid start clears the flag.
- start pulsed again at cycle 3 of 13/3 with divisor=5 -> ignored. Result is still Q=4, R=1.
- rst asserted during SHIFT of iteration 2 -> all outputs 0 asynchronously, state IDLE, busy=0. A new 13/3 then completes correctly.
- Every cycle of every test: assertion that the four strobes are one-hot-or-zero.

Source files
------------

// File: rtl/div_restoring_ctrl.sv
// ---------------------------------------------------------------------------
// div_restoring_ctrl
//   Control and arithmetic stage of an N-bit restoring unsigned divider. It
//   drives the strobes and the operand of the downstream A/Q shift register
//   and reads back that register's A value. It captures the divisor on an
//   accepted start, runs N shift/subtract/restore iterations, and then
//   pulses done for one cycle. After done, the quotient is in Q and the
//   remainder is in A[N-1:0] of the downstream register.
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : division request, sampled only in IDLE
//   divisor     : divisor M, captured when start is accepted
//   regA        : A register value fed back from the A/Q register
//   load        : strobe, A<=0 and Q<=dividend
//   shift       : strobe, {A,Q} shift left by one bit
//   hab_A       : strobe, A<=operando
//   set_Q0      : strobe, Q[0]<=1
//   operando    : regA minus the latched divisor, N+1 bits
//   busy        : high in every state except IDLE
//   done        : one-cycle completion pulse
//   div_by_zero : sticky error flag, cleared by the next accepted start
// ---------------------------------------------------------------------------
module div_restoring_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] divisor,
  input  logic [N:0]   regA,
  output logic         load,
  output logic         shift,
  output logic         hab_A,
  output logic         set_Q0,
  output logic [N:0]   operando,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CHECK,
    SETQ,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  m_reg;
  logic [CW-1:0] cnt;
  logic [N+1:0]  diff;
  logic          diff_nonneg;

  // After a shift, A can reach 2M-1, which may exceed 2^N. The extra top bit
  // keeps the sign of the subtraction correct.
  assign diff        = {1'b0, regA} - {2'b0, m_reg};
  assign diff_nonneg = ~diff[N+1];
  assign operando    = diff[N:0];

  // State register and the datapath registers that advance with it.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values no matter how the statements are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      m_reg       <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg       <= divisor;
            div_by_zero <= (divisor == '0);
          end
        end
        LOAD:    cnt <= CW'(N);
        CHECK:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic. In CHECK and SETQ, cnt counts the iterations that are
  // still open. CHECK compares against the value it holds before it
  // decrements cnt. SETQ sees the value after the decrement.
  always_comb begin
    // NOTE: a default assignment before the case keeps every path assigned,
    // so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : LOAD;
      end
      LOAD:  state_nxt = SHIFT;
      SHIFT: state_nxt = CHECK;
      CHECK: begin
        if (diff_nonneg)        state_nxt = SETQ;
        else if (cnt > CW'(1))  state_nxt = SHIFT;
        else                    state_nxt = DONE;
      end
      SETQ:    state_nxt = (cnt != '0) ? SHIFT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. Each strobe belongs to a different state, so the four
  // strobes can never be high together.
  always_comb begin
    load   = 1'b0;
    shift  = 1'b0;
    hab_A  = 1'b0;
    set_Q0 = 1'b0;
    busy   = (state != IDLE);
    done   = 1'b0;
    case (state)
      LOAD:    load   = 1'b1;
      SHIFT:   shift  = 1'b1;
      CHECK:   hab_A  = diff_nonneg;  // restore skipped: accept A-M
      SETQ:    set_Q0 = 1'b1;
      DONE:    done   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_restoring_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_restoring_ctrl
//   Bench for div_restoring_ctrl (N=4) together with a behavioural A/Q
//   register. Expected results are queued when a start is issued. A monitor
//   pops one entry on each done pulse and compares quotient, remainder,
//   error flag, latency and the number of pulses on each strobe.
// ---------------------------------------------------------------------------
module tb_div_restoring_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] dividend = '0;
  logic [N:0]   regA;
  logic [N-1:0] regQ;
  logic         load, shift, hab_A, set_Q0, busy, done, div_by_zero;
  logic [N:0]   operando;

  always #5 clk = ~clk;

  div_restoring_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .divisor     (divisor),
    .regA        (regA),
    .load        (load),
    .shift       (shift),
    .hab_A       (hab_A),
    .set_Q0      (set_Q0),
    .operando    (operando),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // Behavioural A/Q register: at most one action per edge, with priority
  // load > shift > hab_A > set_Q0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regA <= '0;
      regQ <= '0;
    end else if (load) begin
      regA <= '0;
      regQ <= dividend;
    end else if (shift) begin
      {regA, regQ} <= {regA, regQ} << 1;
    end else if (hab_A) begin
      regA <= operando;
    end else if (set_Q0) begin
      regQ[0] <= 1'b1;
    end
  end

  typedef struct {
    int q;
    int r;
    int dbz;
    int lat;
    int k;
    int loads;
    int shifts;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Counts edges and strobe pulses for the operation in flight.
  int edge_cnt, start_edge, load_n, shift_n, hab_n, setq_n;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt = 0; start_edge = 0;
      load_n = 0; shift_n = 0; hab_n = 0; setq_n = 0;
    end else begin
      edge_cnt++;
      if (start && !busy) begin
        start_edge = edge_cnt;
        load_n = 0; shift_n = 0; hab_n = 0; setq_n = 0;
      end else begin
        load_n  += int'(load);
        shift_n += int'(shift);
        hab_n   += int'(hab_A);
        setq_n  += int'(set_Q0);
      end
    end
  end

  // Monitor: checks the strobes every cycle and checks the scoreboard on
  // each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      assert ($countones({load, shift, hab_A, set_Q0}) <= 1)
        else $error("strobes not one-hot at %0t", $time);
      check("strobe_onehot", int'($countones({load, shift, hab_A, set_Q0}) <= 1), 1);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.dbz == 0) begin
            check("quotient", int'(regQ), e.q);
            check("remainder", int'(regA[N-1:0]), e.r);
          end
          check("div_by_zero", int'(div_by_zero), e.dbz);
          check("latency", edge_cnt - start_edge, e.lat);
          check("hab_A_pulses", hab_n, e.k);
          check("set_Q0_pulses", setq_n, e.k);
          check("load_pulses", load_n, e.loads);
          check("shift_pulses", shift_n, e.shifts);
          check("busy_in_done", int'(busy), 1);
        end
        done_cnt++;
      end
    end
  end

  // Pulses start for one cycle. When push is set, the expected result goes
  // onto the scoreboard.
  task automatic begin_op(input int dvd, input int dvs, input bit push,
                          input int q, input int r, input int dbz,
                          input int lat, input int k);
    exp_t e;
    @(negedge clk);
    dividend = dvd[N-1:0];
    divisor  = dvs[N-1:0];
    start    = 1'b1;
    if (push) begin
      e.q = q; e.r = r; e.dbz = dbz; e.lat = lat; e.k = k;
      e.loads  = dbz ? 0 : 1;
      e.shifts = dbz ? 0 : N;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (dvs != 0) check("dbz_cleared_on_start", int'(div_by_zero), 0);
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("done_timeout", int'(done_cnt > prev), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int prev, shifts_seen, n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_strobes", int'({load, shift, hab_A, set_Q0}), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    check("reset_operando", int'(operando), int'(regA));

    // 13 / 3 = 4 r 1, one quotient 1-bit
    prev = done_cnt;
    begin_op(13, 3, 1'b1, 4, 1, 0, 10, 1);
    wait_done(prev);

    // 15 / 1 = 15 r 0, every iteration restores nothing
    prev = done_cnt;
    begin_op(15, 1, 1'b1, 15, 0, 0, 13, 4);
    wait_done(prev);

    // 7 / 7 = 1 r 0, then back-to-back 2 / 9 = 0 r 2
    prev = done_cnt;
    begin_op(7, 7, 1'b1, 1, 0, 0, 10, 1);
    wait_done(prev);
    prev = done_cnt;
    begin_op(2, 9, 1'b1, 0, 2, 0, 9, 0);
    wait_done(prev);

    // divide by zero: DONE on the sampling edge, flag set, no strobes
    prev = done_cnt;
    begin_op(6, 0, 1'b1, 0, 0, 1, 0, 0);
    wait_done(prev);
    @(negedge clk);
    check("dbz_sticky", int'(div_by_zero), 1);

    // next valid start clears the flag; start pulsed mid-operation is ignored
    prev = done_cnt;
    begin_op(13, 3, 1'b1, 4, 1, 0, 10, 1);
    @(negedge clk);
    start   = 1'b1;
    divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(prev);

    // reset during SHIFT of the second iteration
    begin_op(13, 3, 1'b0, 0, 0, 0, 0, 0);
    shifts_seen = 0;
    n = 0;
    while (shifts_seen < 2 && n < 40) begin
      @(negedge clk);
      if (shift) shifts_seen++;
      n++;
    end
    check("reached_second_shift", shifts_seen, 2);
    #1 rst = 1'b1;
    #1;
    check("midop_reset_busy", int'(busy), 0);
    check("midop_reset_strobes", int'({load, shift, hab_A, set_Q0, done}), 0);
    @(negedge clk);
    rst = 1'b0;
    check("midop_reset_idle_busy", int'(busy), 0);

    prev = done_cnt;
    begin_op(13, 3, 1'b1, 4, 1, 0, 10, 1);
    wait_done(prev);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
